// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU port, auxiliary requester port and RAM port.
// cpu_stall exists only when DMEM_ARB_STALL_EN is defined.
`timescale 1ns/1ps
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic [DATA_W-1:0] cpu_q;
`ifdef DMEM_ARB_STALL_EN
  logic              cpu_stall;
`endif
  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_gnt;
  logic              aux_rvalid;
  logic [DATA_W-1:0] aux_rdata;
  logic              aux_starved;
  logic              ram_wEn;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dataIn;
  logic [DATA_W-1:0] ram_dataOut;

  // Arbiter side: sees both requesters and drives the RAM.
  modport slave (
`ifdef DMEM_ARB_STALL_EN
    output cpu_stall,
`endif
    input  cpu_req, cpu_wren, cpu_addr, cpu_data,
    output cpu_q,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_gnt, aux_rvalid, aux_rdata, aux_starved,
    output ram_wEn, ram_addr, ram_dataIn,
    input  ram_dataOut
  );

  // Environment side: requesters plus the RAM instance.
  modport master (
`ifdef DMEM_ARB_STALL_EN
    input  cpu_stall,
`endif
    output cpu_req, cpu_wren, cpu_addr, cpu_data,
    input  cpu_q,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_gnt, aux_rvalid, aux_rdata, aux_starved,
    input  ram_wEn, ram_addr, ram_dataIn,
    output ram_dataOut
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous data RAM between the CPU (fixed priority, no added
// latency) and one auxiliary requester. Optional macro DMEM_ARB_STALL_EN: forced aux grant on starvation.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 16
) (
  input logic           clock,
  input logic           anti_reset,
  dmem_arbiter_if.slave bus
);
  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RD   = 2'd2,
    S_RET  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              aux_starved_q, aux_starved_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;

  logic              arb_phase_s;
  logic              force_s;
  logic              gnt_s;
  logic              blocked_s;
  logic [ADDR_W-1:0] mux_addr_s;
  logic [DATA_W-1:0] mux_data_s;
  logic              mux_wen_s;

  // Grant decision: aux may only take the port in IDLE/WAIT and never while reset is asserted.
  always_comb begin
    arb_phase_s = (state_q == S_IDLE) || (state_q == S_WAIT);
`ifdef DMEM_ARB_STALL_EN
    force_s = (state_q == S_WAIT) && bus.aux_req && (wait_cnt_q == CNT_MAX);
`else
    force_s = 1'b0;
`endif
    gnt_s     = anti_reset && arb_phase_s && bus.aux_req && (!bus.cpu_req || force_s);
    blocked_s = arb_phase_s && bus.aux_req && bus.cpu_req && !force_s;
  end

  // State register and bookkeeping registers.
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= {CNT_W{1'b0}};
      aux_starved_q <= 1'b0;
      aux_rdata_q   <= {DATA_W{1'b0}};
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      aux_starved_q <= aux_starved_d;
      aux_rdata_q   <= aux_rdata_d;
    end
  end

  // Next-state logic; a dropped request in WAIT simply falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_WAIT: begin
        if (gnt_s) begin
          state_d = bus.aux_we ? S_IDLE : S_RD;
        end else if (blocked_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD:    state_d = S_RET;
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter saturates; starvation flag is sticky until reset.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (gnt_s) begin
      wait_cnt_d = {CNT_W{1'b0}};
    end else if (blocked_s && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CNT_ONE;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    aux_starved_d = aux_starved_q || (wait_cnt_d == CNT_MAX);
    if (state_q == S_RD) begin
      aux_rdata_d = bus.ram_dataOut;
    end else begin
      aux_rdata_d = aux_rdata_q;
    end
  end

  // RAM port mux: aux owns the port only in its grant cycle, otherwise the CPU drives it.
  always_comb begin
    if (gnt_s) begin
      mux_wen_s  = bus.aux_we;
      mux_addr_s = bus.aux_addr;
      mux_data_s = bus.aux_wdata;
    end else begin
      mux_wen_s  = bus.cpu_wren && bus.cpu_req;
      mux_addr_s = bus.cpu_addr;
      mux_data_s = bus.cpu_data;
    end
  end

  // Output decode.
  always_comb begin
    bus.ram_wEn     = mux_wen_s;
    bus.ram_addr    = mux_addr_s;
    bus.ram_dataIn  = mux_data_s;
    bus.cpu_q       = bus.ram_dataOut;
    bus.aux_gnt     = gnt_s;
    bus.aux_rvalid  = (state_q == S_RET);
    bus.aux_rdata   = aux_rdata_q;
    bus.aux_starved = aux_starved_q;
`ifdef DMEM_ARB_STALL_EN
    bus.cpu_stall   = force_s && gnt_s;
`endif
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-cycle behaviour plus
// hand sequences for starvation and reset-in-RD.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clock;
  logic anti_reset;
  int   n_cmp;
  int   n_bad;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(16)) dut (
    .clock      (clock),
    .anti_reset (anti_reset),
    .bus        (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Synchronous single-port RAM, read-before-write.
  always @(posedge clock) begin
    if (bus.ram_wEn) mem[bus.ram_addr] <= bus.ram_dataIn;
    bus.ram_dataOut <= mem[bus.ram_addr];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        cr, cw;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        ar, aw;
    logic [11:0] aa;
    logic [31:0] ad;
    logic        e_gnt, e_rv;
    logic [31:0] e_rdata;
    logic        e_wen;
    logic [11:0] e_addr;
    logic [31:0] e_din;
    logic        chk_q;
    logic [31:0] e_q;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(logic cr, logic cw, logic [11:0] ca, logic [31:0] cd,
                               logic ar, logic aw, logic [11:0] aa, logic [31:0] ad,
                               logic e_gnt, logic e_rv, logic [31:0] e_rdata, logic e_wen,
                               logic [11:0] e_addr, logic [31:0] e_din,
                               logic chk_q, logic [31:0] e_q);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rdata = e_rdata; v.e_wen = e_wen;
    v.e_addr = e_addr; v.e_din = e_din; v.chk_q = chk_q; v.e_q = e_q;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                       input logic ar, input logic aw, input logic [11:0] aa, input logic [31:0] ad);
    bus.cpu_req = cr; bus.cpu_wren = cw; bus.cpu_addr = ca; bus.cpu_data = cd;
    bus.aux_req = ar; bus.aux_we = aw; bus.aux_addr = aa; bus.aux_wdata = ad;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    anti_reset = 1'b0;
    drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);

    // Sequence: CPU preload, idle aux read, blocked aux write, store/read race, dropped request.
    vq.push_back(mkv(1'b1,1'b1,12'h010,32'hDEADBEEF, 1'b0,1'b0,12'h000,32'h0,    1'b0,1'b0,32'h0,       1'b1,12'h010,32'hDEADBEEF, 1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h000,32'h0,        1'b1,1'b0,12'h010,32'h0,    1'b1,1'b0,32'h0,       1'b0,12'h010,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,    1'b0,1'b0,32'h0,       1'b0,12'h000,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,    1'b0,1'b1,32'hDEADBEEF,1'b0,12'h000,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,    1'b0,1'b0,32'hDEADBEEF,1'b0,12'h000,32'h0,        1'b0,32'h0));
    for (int k = 0; k < 5; k++)
      vq.push_back(mkv(1'b1,1'b0,12'h100,32'h0,      1'b1,1'b1,12'h020,32'h1234, 1'b0,1'b0,32'hDEADBEEF,1'b0,12'h100,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h100,32'h0,        1'b1,1'b1,12'h020,32'h1234, 1'b1,1'b0,32'hDEADBEEF,1'b1,12'h020,32'h1234,     1'b0,32'h0));
    vq.push_back(mkv(1'b1,1'b0,12'h020,32'h0,        1'b0,1'b0,12'h000,32'h0,    1'b0,1'b0,32'hDEADBEEF,1'b0,12'h020,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,    1'b0,1'b0,32'hDEADBEEF,1'b0,12'h000,32'h0,        1'b1,32'h1234));
    vq.push_back(mkv(1'b1,1'b1,12'h005,32'hA5,       1'b1,1'b0,12'h005,32'h0,    1'b0,1'b0,32'hDEADBEEF,1'b1,12'h005,32'hA5,       1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h000,32'h0,        1'b1,1'b0,12'h005,32'h0,    1'b1,1'b0,32'hDEADBEEF,1'b0,12'h005,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,    1'b0,1'b0,32'hDEADBEEF,1'b0,12'h000,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,    1'b0,1'b1,32'hA5,      1'b0,12'h000,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h000,32'h0,        1'b0,1'b0,12'h000,32'h0,    1'b0,1'b0,32'hA5,      1'b0,12'h000,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b1,1'b0,12'h030,32'h0,        1'b1,1'b0,12'h040,32'h0,    1'b0,1'b0,32'hA5,      1'b0,12'h030,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b1,1'b0,12'h030,32'h0,        1'b1,1'b0,12'h040,32'h0,    1'b0,1'b0,32'hA5,      1'b0,12'h030,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b1,1'b0,12'h030,32'h0,        1'b0,1'b0,12'h040,32'h0,    1'b0,1'b0,32'hA5,      1'b0,12'h030,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h7FF,32'h0,        1'b0,1'b0,12'h000,32'h0,    1'b0,1'b0,32'hA5,      1'b0,12'h7FF,32'h0,        1'b0,32'h0));
    vq.push_back(mkv(1'b0,1'b0,12'h000,32'h0,        1'b1,1'b1,12'h040,32'h55,   1'b1,1'b0,32'hA5,      1'b1,12'h040,32'h55,       1'b0,32'h0));
    vq.push_back(mkv(1'b1,1'b1,12'h0CC,32'h0,        1'b0,1'b0,12'h000,32'h0,    1'b0,1'b0,32'hA5,      1'b1,12'h0CC,32'h0,        1'b0,32'h0));

    // Reset state, asynchronous and across clock edges.
    #1;
    chk("rst.gnt",     {31'd0, bus.aux_gnt},     32'd0);
    chk("rst.rvalid",  {31'd0, bus.aux_rvalid},  32'd0);
    chk("rst.starved", {31'd0, bus.aux_starved}, 32'd0);
    chk("rst.rdata",   bus.aux_rdata,            32'd0);
    chk("rst.wen",     {31'd0, bus.ram_wEn},     32'd0);
`ifdef DMEM_ARB_STALL_EN
    chk("rst.stall",   {31'd0, bus.cpu_stall},   32'd0);
`endif
    #21;
    anti_reset = 1'b1;
    next_cycle();

    foreach (vq[i]) begin
      drive(vq[i].cr, vq[i].cw, vq[i].ca, vq[i].cd, vq[i].ar, vq[i].aw, vq[i].aa, vq[i].ad);
      @(negedge clock);
      chk($sformatf("v%0d.gnt", i),    {31'd0, bus.aux_gnt},    {31'd0, vq[i].e_gnt});
      chk($sformatf("v%0d.rvalid", i), {31'd0, bus.aux_rvalid}, {31'd0, vq[i].e_rv});
      chk($sformatf("v%0d.rdata", i),  bus.aux_rdata,           vq[i].e_rdata);
      chk($sformatf("v%0d.wen", i),    {31'd0, bus.ram_wEn},    {31'd0, vq[i].e_wen});
      chk($sformatf("v%0d.addr", i),   {20'd0, bus.ram_addr},   {20'd0, vq[i].e_addr});
      chk($sformatf("v%0d.din", i),    bus.ram_dataIn,          vq[i].e_din);
      if (vq[i].chk_q) chk($sformatf("v%0d.cpu_q", i), bus.cpu_q, vq[i].e_q);
      next_cycle();
    end

    // Starvation: CPU store held every cycle while aux write waits.
    drive(1'b1, 1'b1, 12'h0AA, 32'h77, 1'b1, 1'b1, 12'h0BB, 32'h99);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      chk($sformatf("starve.c%0d.gnt", c),     {31'd0, bus.aux_gnt},     32'd0);
      chk($sformatf("starve.c%0d.starved", c), {31'd0, bus.aux_starved}, 32'd0);
      next_cycle();
    end
    bus.cpu_addr = 12'h0CC;
    bus.cpu_data = 32'h66;
    @(negedge clock);
    chk("starve.c17.starved", {31'd0, bus.aux_starved}, 32'd1);
`ifdef DMEM_ARB_STALL_EN
    chk("starve.c17.gnt",   {31'd0, bus.aux_gnt},   32'd1);
    chk("starve.c17.stall", {31'd0, bus.cpu_stall}, 32'd1);
    chk("starve.c17.addr",  {20'd0, bus.ram_addr},  32'h0BB);
    chk("starve.c17.din",   bus.ram_dataIn,         32'h99);
    next_cycle();
    drive(1'b1, 1'b0, 12'h0CC, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    @(negedge clock);
    chk("post.stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("post.gnt",   {31'd0, bus.aux_gnt},   32'd0);
    next_cycle();
    bus.cpu_req = 1'b0;
    @(negedge clock);
    chk("post.cpu_q_0CC", bus.cpu_q, 32'h0);
`else
    chk("starve.c17.gnt",  {31'd0, bus.aux_gnt},  32'd0);
    chk("starve.c17.addr", {20'd0, bus.ram_addr}, 32'h0CC);
    next_cycle();
    for (int c = 18; c <= 20; c++) begin
      @(negedge clock);
      chk($sformatf("starve.c%0d.gnt", c),     {31'd0, bus.aux_gnt},     32'd0);
      chk($sformatf("starve.c%0d.starved", c), {31'd0, bus.aux_starved}, 32'd1);
      next_cycle();
    end
    bus.cpu_req = 1'b0;
    @(negedge clock);
    chk("release.gnt",  {31'd0, bus.aux_gnt},  32'd1);
    chk("release.addr", {20'd0, bus.ram_addr}, 32'h0BB);
    next_cycle();
    drive(1'b1, 1'b0, 12'h0CC, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    next_cycle();
    bus.cpu_req = 1'b0;
    @(negedge clock);
    chk("post.cpu_q_0CC", bus.cpu_q, 32'h66);
`endif

    // Reset asserted while a read sits in RD: no rvalid may follow.
    next_cycle();
    drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h010, 32'h0);
    @(negedge clock);
    chk("rdrst.gnt", {31'd0, bus.aux_gnt}, 32'd1);
    next_cycle();
    bus.aux_req = 1'b0;
    #2;
    anti_reset = 1'b0;
    #1;
    chk("rdrst.async.rvalid",  {31'd0, bus.aux_rvalid},  32'd0);
    chk("rdrst.async.starved", {31'd0, bus.aux_starved}, 32'd0);
    chk("rdrst.async.rdata",   bus.aux_rdata,            32'd0);
    chk("rdrst.async.gnt",     {31'd0, bus.aux_gnt},     32'd0);
`ifdef DMEM_ARB_STALL_EN
    chk("rdrst.async.stall",   {31'd0, bus.cpu_stall},   32'd0);
`endif
    @(posedge clock);
    #3;
    anti_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("rdrst.c%0d.rvalid", c), {31'd0, bus.aux_rvalid}, 32'd0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h005, 32'h0);
    @(negedge clock);
    chk("afterrst.gnt", {31'd0, bus.aux_gnt}, 32'd1);
    next_cycle();
    bus.aux_req = 1'b0;
    @(negedge clock);
    chk("afterrst.rd_rvalid", {31'd0, bus.aux_rvalid}, 32'd0);
    next_cycle();
    @(negedge clock);
    chk("afterrst.rvalid", {31'd0, bus.aux_rvalid}, 32'd1);
    chk("afterrst.rdata",  bus.aux_rdata,           32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
